instr_loader: RTL

Program loader that fills the CPU's instruction memory from a byte stream before execution begins. It is the writer for the instruction-memory read port that the CPU fetches from. It accepts a framed byte stream (length header, little-endian instruction words, XOR checksum) and issues one word write per instruction. It holds the CPU in reset while loading and reports completion or error.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/byte_packer.sv | 41 ++++
 rtl/instr_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
//   loader_state_t : loader FSM state encoding
//   LEN_BYTES      : bytes in the frame length header
//   WORD_BYTES     : bytes per instruction word
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } loader_state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
//   clk, rst   : clock, async active-low reset
//   clr        : restart packing at byte lane 0
//   push       : byte_in is consumed this cycle
//   byte_in    : stream byte
//   word_out   : assembled word, valid when word_done is high
//   word_done  : this push completes a word (combinational, same cycle)
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_done
);

  logic [1:0]  idx_q;
  logic [23:0] lanes_q;

  // The fourth byte is not stored; it is combined directly so the caller can
  // register the full word on the same edge that accepts that byte.
  assign word_out  = {byte_in, lanes_q};
  assign word_done = push && (idx_q == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= 2'd0;
      lanes_q <= 24'd0;
    end else if (clr) begin
      idx_q   <= 2'd0;
      lanes_q <= 24'd0;
    end else if (push) begin
      idx_q   <= idx_q + 2'd1;
      lanes_q <= {byte_in, lanes_q[23:8]};
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads instruction memory from a framed byte stream while holding the CPU
// in reset. Frame: LEN_LO, LEN_HI, 4*N little-endian payload bytes, XOR cs.
//   clk, rst        : clock, async active-low reset
//   load_req        : pulse to start a load (only honoured when not loading)
//   in_valid/in_data/in_ready : byte stream handshake
//   mem_wen/mem_addr/mem_wdata: one-cycle word write strobe, address, data
//   cpu_hold        : CPU held in reset
//   done / error    : result of the last load
//   words_loaded    : words written in the current or last load
//
// state    | meaning
// ---------+---------------------------------------------
// S_IDLE   | no load since reset
// S_LEN_LO | waiting for length low byte
// S_LEN_HI | waiting for length high byte, range check
// S_DATA   | receiving payload, one write per 4 bytes
// S_CHECK  | waiting for checksum byte
// S_DONE   | load good, CPU released
// S_ERR    | load failed (oversize or bad checksum)
module instr_loader
  import loader_pkg::*;
#(
  parameter int PC_WIDTH   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_req,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_wen,
  output logic [PC_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [PC_WIDTH-3:0]   words_loaded
);

  localparam logic [PC_WIDTH-1:0] BASE      = PC_WIDTH'(BASE_ADDR);
  localparam logic [31:0]         MAX_WORDS = 32'((1 << (PC_WIDTH - 2)) - (BASE_ADDR / 4));
  localparam logic [PC_WIDTH-3:0] WL_ONE    = 1;

  loader_state_t         state_q;
  logic [7:0]            len_lo_q;
  logic [15:0]           rem_q;
  logic [7:0]            xor_q;
  logic                  mem_wen_q;
  logic [PC_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  cpu_hold_q;
  logic                  done_q;
  logic                  error_q;
  logic [PC_WIDTH-3:0]   words_q;

  logic                  xfer;
  logic                  start;
  logic [15:0]           len_d;
  logic [PC_WIDTH-1:0]   addr_d;
  logic [31:0]           word;
  logic                  word_done;

  assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CHECK);
  assign xfer     = in_valid && in_ready;
  assign start    = load_req && !in_ready;
  assign len_d    = {in_data, len_lo_q};
  assign addr_d   = BASE + {words_q, 2'b00};

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .push      (xfer && (state_q == S_DATA)),
    .byte_in   (in_data),
    .word_out  (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      len_lo_q    <= 8'd0;
      rem_q       <= 16'd0;
      xor_q       <= 8'd0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      words_q     <= '0;
    end else begin
      mem_wen_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q    <= S_LEN_LO;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
            xor_q      <= 8'd0;
            cpu_hold_q <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_lo_q <= in_data;
            xor_q    <= xor_q ^ in_data;
            state_q  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            xor_q <= xor_q ^ in_data;
            rem_q <= len_d;
            if ({16'd0, len_d} > MAX_WORDS) begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end else if (len_d == 16'd0) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            xor_q <= xor_q ^ in_data;
            if (word_done) begin
              mem_wen_q   <= 1'b1;
              mem_addr_q  <= addr_d;
              mem_wdata_q <= DATA_WIDTH'(word);
              words_q     <= words_q + WL_ONE;
              rem_q       <= rem_q - 16'd1;
              // rem_q counts down the words still to write; 1 means this was the last
              if (rem_q == 16'd1) state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (in_data == xor_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_wen      = mem_wen_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule
